// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder tree and its upstream feeder.
package adder_tree_pkg;
  localparam int ADDER_WIDTH  = 14;
  localparam int LANES        = 8;
  localparam int TREE_LATENCY = 2;
  localparam int LEN_W        = $clog2(LANES + 1);

  typedef logic [ADDER_WIDTH-1:0] lane_t;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } feeder_state_e;
endpackage

// File: rtl/adder_tree_feeder_if.sv
// Bundle between a sample source / tree consumer (master) and the feeder (slave).
// Handshake: a sample transfers on a rising clk edge where in_valid and in_ready are both 1;
// in_data/in_last are only meaningful with in_valid, and in_ready never depends on in_valid.
interface adder_tree_feeder_if #(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int LANES       = adder_tree_pkg::LANES,
  parameter int LEN_W       = adder_tree_pkg::LEN_W
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [ADDER_WIDTH-1:0]       in_data;
  logic                         in_last;
  logic                         hold;
  logic [LANES*ADDER_WIDTH-1:0] lanes;
  logic                         frame_valid;
  logic [LEN_W-1:0]             frame_len;
  logic                         sum_valid;
  logic [LEN_W-1:0]             sum_len;

  modport master (
    output in_valid, in_data, in_last, hold,
    input  in_ready, lanes, frame_valid, frame_len, sum_valid, sum_len
  );

  modport slave (
    input  in_valid, in_data, in_last, hold,
    output in_ready, lanes, frame_valid, frame_len, sum_valid, sum_len
  );
endinterface

// File: rtl/adder_tree_delay.sv
// Free-running shift register with async reset; aligns commit strobes to the tree output.
module adder_tree_delay #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a serial sample stream into parallel tree lanes, one frame at a time, and
// emits a length-tagged strobe aligned with the tree's registered sum.
module adder_tree_feeder #(
  parameter int ADDER_WIDTH  = adder_tree_pkg::ADDER_WIDTH,
  parameter int LANES        = adder_tree_pkg::LANES,
  parameter int TREE_LATENCY = adder_tree_pkg::TREE_LATENCY,
  parameter int LEN_W        = adder_tree_pkg::LEN_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  adder_tree_feeder_if.slave             bus,
  output adder_tree_pkg::feeder_state_e  state_o
);
  import adder_tree_pkg::*;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  logic [0:0]                         state_q, state_d;
  logic [LEN_W-1:0]                   idx_q, idx_d;
  logic [LANES-1:0][ADDER_WIDTH-1:0]  buf_q, buf_d;
  logic [LANES-1:0][ADDER_WIDTH-1:0]  lanes_q, lanes_d;
  logic [LEN_W-1:0]                   frame_len_q, frame_len_d;
  logic                               frame_valid_q, frame_valid_d;
  logic [LEN_W:0]                     dly_out;
  logic                               hs;

  // in_ready is a pure state decode; rst_n gating keeps it low throughout reset.
  assign bus.in_ready = rst_n && (state_q == ST_FILL);
  assign hs           = bus.in_valid && bus.in_ready;
  assign state_o      = (state_q == ST_COMMIT) ? COMMIT : FILL;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    lanes_d       = lanes_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (hs) begin
          buf_d[idx_q[IDX_W-1:0]] = bus.in_data;
          idx_d = idx_q + 1'b1;
          if (idx_q == LEN_W'(LANES - 1) || bus.in_last) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (!bus.hold) begin
          // Lanes past the frame length are zeroed so short frames sum correctly.
          for (int k = 0; k < LANES; k++) begin
            lanes_d[k] = (LEN_W'(k) < idx_q) ? buf_q[k] : '0;
          end
          frame_len_d   = idx_q;
          frame_valid_d = 1'b1;
          buf_d         = '0;
          idx_d         = '0;
          state_d       = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      idx_q         <= '0;
      buf_q         <= '0;
      lanes_q       <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      lanes_q       <= lanes_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.lanes       = lanes_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_valid = frame_valid_q;

  adder_tree_delay #(
    .WIDTH (LEN_W + 1),
    .DEPTH (TREE_LATENCY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({frame_valid_q, frame_len_q}),
    .q_o   (dly_out)
  );

  assign bus.sum_valid = dly_out[LEN_W];
  assign bus.sum_len   = dly_out[LEN_W-1:0];
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Self-checking bench for adder_tree_feeder with a frame-level reference model and a
// behavioural two-stage tree standing in for adder_tree_top.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  localparam int W  = ADDER_WIDTH;
  localparam int L  = LANES;
  localparam int LW = LEN_W;

  logic          clk;
  logic          rst_n;
  feeder_state_e state_dbg;
  int            total = 0;
  int            bad   = 0;

  logic [L*W-1:0] prev_lanes;
  logic [W:0]     tree_s1, tree_s2;
  lane_t          exp_q[$];

  adder_tree_feeder_if bus ();

  adder_tree_feeder u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for adder_tree_top: registered sum of all lanes, truncated to W+1 bits.
  function automatic logic [W:0] tree_add(input logic [L*W-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < L; k++) s += int'(v[k*W +: W]);
    return s[W:0];
  endfunction

  always @(posedge clk) begin
    tree_s1 <= tree_add(bus.lanes);
    tree_s2 <= tree_s1;
  end

  function automatic logic [L*W-1:0] expected_lanes();
    logic [L*W-1:0] v;
    v = '0;
    foreach (exp_q[i]) v[i*W +: W] = exp_q[i];
    return v;
  endfunction

  function automatic logic [W:0] expected_sum();
    int s;
    s = 0;
    foreach (exp_q[i]) s += int'(exp_q[i]);
    return s[W:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"},    128'(bus.in_ready),    128'(0));
    chk({tag, "_lanes"},       128'(bus.lanes),       128'(0));
    chk({tag, "_frame_len"},   128'(bus.frame_len),   128'(0));
    chk({tag, "_frame_valid"}, 128'(bus.frame_valid), 128'(0));
    chk({tag, "_sum_valid"},   128'(bus.sum_valid),   128'(0));
    chk({tag, "_sum_len"},     128'(bus.sum_len),     128'(0));
    chk({tag, "_state"},       128'(state_dbg),       128'(FILL));
  endtask

  // driver: called and returns at a negedge. vmode 0=random, 1=base*(i+1), 2=constant base.
  task automatic run_frame(input int n, input bit gaps, input int hold_cycles,
                           input int vmode, input lane_t base, input bit wait_sum);
    lane_t v;
    exp_q.delete();
    bus.hold = (hold_cycles > 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
      end
      case (vmode)
        1:       v = lane_t'(int'(base) * (i + 1));
        2:       v = base;
        default: v = lane_t'($urandom);
      endcase
      exp_q.push_back(v);
      chk("ready_fill", 128'(bus.in_ready), 128'(1));
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      bus.in_last  = (i == n - 1) && (n < L || $urandom_range(0, 1) == 1);
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int h = 0; h <= hold_cycles; h++) begin
      chk("ready_commit", 128'(bus.in_ready),    128'(0));
      chk("fv_before",    128'(bus.frame_valid), 128'(0));
      chk("lanes_kept",   128'(bus.lanes),       128'(prev_lanes));
      bus.hold = (h < hold_cycles);
      @(posedge clk); @(negedge clk);
    end
    chk("frame_valid", 128'(bus.frame_valid), 128'(1));
    chk("lanes",       128'(bus.lanes),       128'(expected_lanes()));
    chk("frame_len",   128'(bus.frame_len),   128'(n));
    chk("ready_after", 128'(bus.in_ready),    128'(1));
    chk("sv_early",    128'(bus.sum_valid),   128'(0));
    prev_lanes = expected_lanes();
    if (wait_sum) begin
      @(posedge clk); @(negedge clk);
      chk("fv_pulse",  128'(bus.frame_valid), 128'(0));
      chk("sv_early1", 128'(bus.sum_valid),   128'(0));
      @(posedge clk); @(negedge clk);
      chk("sum_valid", 128'(bus.sum_valid), 128'(1));
      chk("sum_len",   128'(bus.sum_len),   128'(n));
      chk("tree_sum",  128'(tree_s2),       128'(expected_sum()));
      @(posedge clk); @(negedge clk);
      chk("sv_pulse",  128'(bus.sum_valid), 128'(0));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.hold     = 1'b0;
    prev_lanes   = '0;
    @(negedge clk); @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_out_of_reset", 128'(bus.in_ready), 128'(1));

    // Directed frames from the plan.
    run_frame(8, 1'b0, 0, 1, lane_t'(1),      1'b1);   // 1..8, sum 36
    run_frame(3, 1'b0, 0, 1, lane_t'('h100),  1'b1);   // short frame, sum 0x600
    run_frame(8, 1'b0, 0, 2, lane_t'('h3FFF), 1'b1);   // sum wraps to 0x7FF8
    run_frame(8, 1'b0, 5, 0, lane_t'(0),      1'b1);   // hold for 5 cycles
    run_frame(8, 1'b1, 0, 0, lane_t'(0),      1'b1);   // valid every other cycle
    run_frame(1, 1'b0, 0, 0, lane_t'(0),      1'b1);   // single-sample frame

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, L), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                0, lane_t'(0), 1'b1);
    end

    // Reset after 4 accepted samples.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = lane_t'($urandom);
      bus.in_last  = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_lanes = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_sv_after_reset1", 128'(bus.sum_valid), 128'(0));
    end

    // Reset one cycle after a commit: the in-flight sum_valid must never appear.
    run_frame(5, 1'b0, 0, 0, lane_t'(0), 1'b0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("post_commit_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_lanes = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_sv_after_reset2", 128'(bus.sum_valid), 128'(0));
    end

    // Next frame must restart at lane 0.
    run_frame(6, 1'b0, 0, 0, lane_t'(0), 1'b1);
    run_frame(8, 1'b0, 1, 0, lane_t'(0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
